prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the memory/fetcher path. It holds the core in reset and takes ownership of the memory port. It then streams a program image from a host byte interface into memory, optionally read-back verifies it with a checksum, releases core reset and pulses `trigger_program` to start the fetcher. This replaces the bench-side manual memory fill and the ad-hoc trigger sequence.

---
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader.sv | 182 ++++++++++++++++++
 tb/tb_prog_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Host byte stream and memory port bundle for the boot-time program loader.
// Latency: none (wires only).
// Backpressure: s_ready from the loader throttles the host; the memory side has none.
// Ports: s_valid/s_data/s_ready host bytes; mem_addr/mem_din/mem_we/mem_dout memory port.
// master = loader side, slave = host + memory side.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8
);
    logic                  s_valid;
    logic [REG_WIDTH-1:0]  s_data;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_din;
    logic                  mem_we;
    logic [REG_WIDTH-1:0]  mem_dout;

    modport master (
        input  s_valid, s_data, mem_dout,
        output s_ready, mem_addr, mem_din, mem_we
    );

    modport slave (
        output s_valid, s_data, mem_dout,
        input  s_ready, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time loader: holds the core in reset, streams a host image into memory, optionally verifies it by checksum, then releases reset and fires trigger_program.
// Latency: start -> WRITE next cycle; L write cycles; L+1 verify cycles; RELEASE, TRIGGER, DONE one cycle apart.
// Backpressure: s_ready high only in WRITE; a missing s_valid stalls WRITE indefinitely without writing.
// Ports: clk, reset_n (async active-low); start/base_addr/length/verify_en session request;
//        bus (host stream + memory port); manual_mem, core_reset_n, trigger_program, busy, done, error status.
module prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  verify_en,
    prog_loader_if.master         bus,
    output logic                  manual_mem,
    output logic                  core_reset_n,
    output logic                  trigger_program,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_VERIFY,
        ST_RELEASE,
        ST_TRIGGER,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic                  verify_q;
    // addr_q/rem_q serve the write pass, then are reloaded for the read pass.
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] rem_q;
    logic [REG_WIDTH-1:0]  wsum_q;
    logic [REG_WIDTH-1:0]  rsum_q;
    logic [REG_WIDTH-1:0]  rsum_d;
    // A read was issued last cycle, so mem_dout carries its data now.
    logic                  rd_pend_q;
    logic                  s_ready_q;
    logic                  core_reset_n_q;
    logic                  manual_mem_q;
    logic                  trigger_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  wr_fire;
    logic                  rd_issue;

    always_comb begin
        wr_fire  = s_ready_q && bus.s_valid;
        rd_issue = (state_q == ST_VERIFY) && (rem_q != '0);
        rsum_d   = rsum_q + (rd_pend_q ? bus.mem_dout : '0);
    end

    // Write strobe, data and address follow the accepted byte in the same cycle.
    assign bus.s_ready  = s_ready_q;
    assign bus.mem_we   = wr_fire;
    assign bus.mem_din  = wr_fire ? bus.s_data : '0;
    assign bus.mem_addr = (state_q == ST_WRITE || state_q == ST_VERIFY) ? addr_q : '0;

    assign manual_mem      = manual_mem_q;
    assign core_reset_n    = core_reset_n_q;
    assign trigger_program = trigger_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            len_q          <= '0;
            verify_q       <= 1'b0;
            addr_q         <= '0;
            rem_q          <= '0;
            wsum_q         <= '0;
            rsum_q         <= '0;
            rd_pend_q      <= 1'b0;
            s_ready_q      <= 1'b0;
            core_reset_n_q <= 1'b0;
            manual_mem_q   <= 1'b1;
            trigger_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            trigger_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        base_q    <= base_addr;
                        len_q     <= length;
                        verify_q  <= verify_en;
                        addr_q    <= base_addr;
                        rem_q     <= length;
                        wsum_q    <= '0;
                        rsum_q    <= '0;
                        rd_pend_q <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        if (length == '0) begin
                            // Nothing to load: release the core straight away.
                            state_q        <= ST_RELEASE;
                            core_reset_n_q <= 1'b1;
                            manual_mem_q   <= 1'b0;
                        end else begin
                            state_q        <= ST_WRITE;
                            s_ready_q      <= 1'b1;
                            core_reset_n_q <= 1'b0;
                            manual_mem_q   <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (wr_fire) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        rem_q  <= rem_q - ADDR_WIDTH'(1);
                        wsum_q <= wsum_q + bus.s_data;
                        if (rem_q == ADDR_WIDTH'(1)) begin
                            s_ready_q <= 1'b0;
                            if (verify_q) begin
                                state_q <= ST_VERIFY;
                                addr_q  <= base_q;
                                rem_q   <= len_q;
                            end else begin
                                state_q        <= ST_RELEASE;
                                core_reset_n_q <= 1'b1;
                                manual_mem_q   <= 1'b0;
                            end
                        end
                    end
                end

                ST_VERIFY: begin
                    rsum_q    <= rsum_d;
                    rd_pend_q <= rd_issue;
                    if (rd_issue) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        rem_q  <= rem_q - ADDR_WIDTH'(1);
                    end else if (rsum_d == wsum_q) begin
                        // Compare cycle: rsum_d already includes the final read byte.
                        state_q        <= ST_RELEASE;
                        core_reset_n_q <= 1'b1;
                        manual_mem_q   <= 1'b0;
                    end else begin
                        // Core stays in reset and the loader keeps the memory port.
                        state_q <= ST_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end

                ST_RELEASE: begin
                    state_q   <= ST_TRIGGER;
                    trigger_q <= 1'b1;
                end

                ST_TRIGGER: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a behavioural synchronous memory and a read fault injector.
// Latency: memory read data appears one clock after the address, like the real RAM.
// Backpressure: host stream driven by directed steps, including stalls.
module tb_prog_loader;
    localparam int AW = 16;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic          verify_en;
    logic          manual_mem;
    logic          core_reset_n;
    logic          trigger_program;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;
    int we_cnt = 0;
    int trig0;
    int we0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  img [0:3];
    logic        fault_en = 1'b0;
    logic [15:0] fault_addr = 16'h0;

    prog_loader_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

    prog_loader #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .length          (length),
        .verify_en       (verify_en),
        .bus             (bus),
        .manual_mem      (manual_mem),
        .core_reset_n    (core_reset_n),
        .trigger_program (trigger_program),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    // Synchronous RAM; optional bit-0 flip on a read of fault_addr.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr] ^
                        ((fault_en && !bus.mem_we && bus.mem_addr == fault_addr) ? 8'h01 : 8'h00);
    end

    always @(posedge clk) begin
        if (trigger_program) trig_cnt++;
        if (bus.mem_we) we_cnt++;
    end

    function automatic logic [31:0] pk(input logic sr, input logic we, input logic [15:0] a,
                                       input logic [7:0] d, input logic crn, input logic mm,
                                       input logic tp, input logic bz, input logic dn, input logic er);
        return {sr, we, a, d, crn, mm, tp, bz, dn, er};
    endfunction

    function automatic logic [31:0] act();
        return pk(bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_din, core_reset_n,
                  manual_mem, trigger_program, busy, done, error);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues start at the next negedge; returns at the negedge after it was sampled.
    task automatic begin_load(input logic [15:0] b, input logic [15:0] n, input logic v);
        @(negedge clk);
        start = 1'b1; base_addr = b; length = n; verify_en = v;
        @(negedge clk);
        start = 1'b0;
        #1 chk("write_entry", act(), pk(1'b1, 1'b0, b, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic stream(input logic [15:0] b, input int n, input int st_idx, input int st_cyc);
        for (int i = 0; i < n; i++) begin
            if (i == st_idx) begin
                for (int c = 0; c < st_cyc; c++) begin
                    bus.s_valid = 1'b0;
                    #1 chk("stall", act(), pk(1'b1, 1'b0, b + 16'(i), 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
                    @(negedge clk);
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = img[i];
            #1 chk("write_byte", act(), pk(1'b1, 1'b1, b + 16'(i), img[i], 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    // Checks the read addresses, then steps over the compare cycle.
    task automatic run_verify(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            #1 chk("verify_read", act(), pk(1'b0, 1'b0, b + 16'(i), 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // Called at the negedge where RELEASE is expected.
    task automatic finish_ok();
        #1 chk("release", act(), pk(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        #1 chk("trigger", act(), pk(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        #1 chk("done", act(), pk(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b0; base_addr = 16'h0; length = 16'h0; verify_en = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 8'h00;
        mem[16'h0041] = 8'hEE;
        #3 reset_n = 1'b0;
        #1 chk("reset_vals", act(), pk(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        // Idle must ignore s_valid.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1 chk("idle_no_ready", act(), pk(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        bus.s_valid = 1'b0;

        // Plain load, no verify: release 5, trigger 6, done 7 cycles after start.
        img[0] = 8'hA9; img[1] = 8'h05; img[2] = 8'h8D; img[3] = 8'h20;
        trig0 = trig_cnt;
        begin_load(16'h0010, 16'd4, 1'b0);
        stream(16'h0010, 4, -1, 0);
        finish_ok();
        chk("mem_plain", {mem[16'h0010], mem[16'h0011], mem[16'h0012], mem[16'h0013]}, 32'hA9058D20);
        chk("trig_once_plain", 32'(trig_cnt - trig0), 32'd1);

        // Verify on, 3-cycle stall before the third byte.
        trig0 = trig_cnt;
        begin_load(16'h0010, 16'd4, 1'b1);
        stream(16'h0010, 4, 2, 3);
        chk("wsum", {24'h0, dut.wsum_q}, 32'h5B);
        run_verify(16'h0010, 4);
        chk("rsum", {24'h0, dut.rsum_q}, 32'h5B);
        finish_ok();
        chk("trig_once_verify", 32'(trig_cnt - trig0), 32'd1);

        // Corrupted read of 0x0012 must end in ERROR with the core held.
        trig0 = trig_cnt;
        fault_en = 1'b1; fault_addr = 16'h0012;
        begin_load(16'h0010, 16'd4, 1'b1);
        stream(16'h0010, 4, -1, 0);
        run_verify(16'h0010, 4);
        fault_en = 1'b0;
        #1 chk("error_state", act(), pk(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (3) @(negedge clk);
        #1 chk("error_held", act(), pk(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        chk("no_trig_on_error", 32'(trig_cnt - trig0), 32'd0);

        // Address wrap through 0xFFFF, verified (sum 0xAA).
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        begin_load(16'hFFFE, 16'd4, 1'b1);
        stream(16'hFFFE, 4, -1, 0);
        run_verify(16'hFFFE, 4);
        finish_ok();
        chk("mem_wrap", {mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]}, 32'h11223344);

        // Zero length: straight to RELEASE without any write.
        we0 = we_cnt;
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0200; length = 16'd0; verify_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_ok();
        chk("len0_no_we", 32'(we_cnt - we0), 32'd0);

        // Asynchronous reset during the second byte.
        img[0] = 8'h5A; img[1] = 8'hC3; img[2] = 8'h3C; img[3] = 8'hA5;
        begin_load(16'h0040, 16'd4, 1'b0);
        bus.s_valid = 1'b1; bus.s_data = img[0];
        @(negedge clk);
        bus.s_data = img[1];
        #2 reset_n = 1'b0;
        #1 chk("async_reset", act(), pk(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk("mem_kept_aborted", {16'h0, mem[16'h0040], mem[16'h0041]}, 32'h00005AEE);
        reset_n = 1'b1;

        // Fresh session with start held high through WRITE; stale requests must be ignored.
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0040; length = 16'd4; verify_en = 1'b0;
        @(negedge clk);
        base_addr = 16'h0100; length = 16'd1;
        #1 chk("write_entry_2", act(), pk(1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        stream(16'h0040, 4, -1, 0);
        start = 1'b0;
        finish_ok();
        chk("mem_after_reset", {mem[16'h0040], mem[16'h0041], mem[16'h0042], mem[16'h0043]}, 32'h5AC33CA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
